// File: rtl/micro_seq_pkg.sv
// micro_seq_pkg: microword field layout, branch conditions, FSM states and control-word type for micro_sequencer.
package micro_seq_pkg;
    localparam int ALU_LO  = 24;
    localparam int CSEL_LO = 15;
    localparam int BSEL_LO = 11;
    localparam int COND_LO = 8;
    localparam int NEXT_LO = 0;
    typedef enum logic [2:0] {
        COND_NEXT, COND_JMP, COND_JN, COND_JZ, COND_JNN, COND_JNZ, COND_END, COND_RSVD
    } cond_e;
    typedef enum logic {ST_IDLE, ST_RUN} state_e;
    typedef struct packed {
        logic [7:0] alu;
        logic [8:0] c_sel;
        logic [3:0] b_sel;
    } ctrl_t;
    localparam ctrl_t CTRL_NOP = '0;
    function automatic ctrl_t word_ctrl(input logic [31:0] w);
        word_ctrl = '{alu: w[ALU_LO +: 8], c_sel: w[CSEL_LO +: 9], b_sel: w[BSEL_LO +: 4]};
    endfunction
endpackage

// File: rtl/micro_sequencer_ucode_store.sv
// ucode_store: microstore RAM with a synchronous write port and an asynchronous read port; never reset.
module ucode_store #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];
    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer: dispatches opcodes into a writable microstore and drives datapath controls per microword.
// Define UCODE_STEP_LIMIT_EN to abort routines after MAX_STEPS microwords and raise a sticky step_err.
module micro_sequencer
    import micro_seq_pkg::*;
#(
    parameter int UADDR_W   = 8,
    parameter int WORD_W    = 32,
    parameter int MAX_STEPS = 1024
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               instr_valid,
    input  logic [7:0]         instr_opcode,
    output logic               instr_ready,
    input  logic               n,
    input  logic               z,
    output logic [7:0]         alu_shifter_opcode,
    output logic [8:0]         c_select,
    output logic [3:0]         b_select,
    output logic               busy,
    output logic               done,
`ifdef UCODE_STEP_LIMIT_EN
    output logic               step_err,
`endif
    input  logic               ucode_we,
    input  logic [UADDR_W-1:0] ucode_addr,
    input  logic [31:0]        ucode_wdata
);
    if (UADDR_W < 1 || UADDR_W > 8) begin : g_bad_uaddr
        $error("UADDR_W must be in 1..8");
    end
    if (WORD_W != 32) begin : g_bad_word
        $error("WORD_W is fixed at 32");
    end
    if (MAX_STEPS < 1) begin : g_bad_steps
        $error("MAX_STEPS must be at least 1");
    end
    state_e state_q, state_d;
    logic [UADDR_W-1:0] upc_q, upc_d, target;
    logic n_q, n_d, z_q, z_d, done_q, done_d, taken, is_end;
    logic [WORD_W-1:0] uword;
    cond_e cond;
    ctrl_t ctrl;
`ifdef UCODE_STEP_LIMIT_EN
    localparam int STEPS_W = $clog2(MAX_STEPS + 1);
    logic [STEPS_W-1:0] steps_q, steps_d;
    logic step_err_q, step_err_d;
    assign step_err = step_err_q;
`endif
    ucode_store #(.AW(UADDR_W), .DW(WORD_W)) u_store (
        .clock (clock),
        .we    (ucode_we && state_q == ST_IDLE),
        .waddr (ucode_addr),
        .wdata (ucode_wdata),
        .raddr (upc_q),
        .rdata (uword)
    );
    always_comb begin
        cond    = cond_e'(uword[COND_LO +: 3]);
        target  = uword[NEXT_LO +: UADDR_W];
        is_end  = cond == COND_END || cond == COND_RSVD;
        taken   = cond == COND_JMP || (cond == COND_JN && n_q) || (cond == COND_JZ && z_q)
                || (cond == COND_JNN && !n_q) || (cond == COND_JNZ && !z_q);
        state_d = state_q;
        upc_d   = upc_q;
        n_d     = n_q;
        z_d     = z_q;
        done_d  = 1'b0;
`ifdef UCODE_STEP_LIMIT_EN
        steps_d    = steps_q;
        step_err_d = step_err_q;
`endif
        if (state_q == ST_IDLE) begin
            if (instr_valid) begin
                state_d = ST_RUN;
                upc_d   = instr_opcode[UADDR_W-1:0];
                n_d     = 1'b0;
                z_d     = 1'b0;
`ifdef UCODE_STEP_LIMIT_EN
                steps_d = '0;
`endif
            end
        end else begin
            n_d     = n;
            z_d     = z;
            upc_d   = taken ? target : upc_q + 1'b1;
            state_d = is_end ? ST_IDLE : ST_RUN;
            done_d  = is_end;
`ifdef UCODE_STEP_LIMIT_EN
            // Leaving here makes the would-be extra microword an ordinary IDLE cycle.
            steps_d = steps_q + 1'b1;
            if (!is_end && steps_q == STEPS_W'(MAX_STEPS - 1)) begin
                state_d    = ST_IDLE;
                step_err_d = 1'b1;
            end
`endif
        end
        ctrl = state_q == ST_RUN ? word_ctrl(uword) : CTRL_NOP;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            upc_q   <= '0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            done_q  <= 1'b0;
`ifdef UCODE_STEP_LIMIT_EN
            steps_q    <= '0;
            step_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            upc_q   <= upc_d;
            n_q     <= n_d;
            z_q     <= z_d;
            done_q  <= done_d;
`ifdef UCODE_STEP_LIMIT_EN
            steps_q    <= steps_d;
            step_err_q <= step_err_d;
`endif
        end
    end
    assign instr_ready        = state_q == ST_IDLE;
    assign busy               = state_q == ST_RUN;
    assign done               = done_q;
    assign alu_shifter_opcode = ctrl.alu;
    assign c_select           = ctrl.c_sel;
    assign b_select           = ctrl.b_sel;
endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: table vectors, hand-written corner sequences and a randomized run against a reference model.
module tb_micro_sequencer;
`ifdef UCODE_STEP_LIMIT_EN
    localparam int MS = 4;
    localparam bit LIMIT = 1'b1;
`else
    localparam int MS = 1024;
    localparam bit LIMIT = 1'b0;
`endif
    logic clock = 1'b0, reset = 1'b1;
    logic instr_valid = 1'b0, n = 1'b0, z = 1'b0, ucode_we = 1'b0;
    logic [7:0] instr_opcode = '0, ucode_addr = '0;
    logic [31:0] ucode_wdata = '0;
    logic instr_ready, busy, done, err_w;
    logic [7:0] alu_shifter_opcode;
    logic [8:0] c_select;
    logic [3:0] b_select;
    int checks = 0, errors = 0;
    always #5 clock = ~clock;

    micro_sequencer #(.UADDR_W(8), .WORD_W(32), .MAX_STEPS(MS)) dut (
        .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr_opcode(instr_opcode),
        .instr_ready(instr_ready), .n(n), .z(z), .alu_shifter_opcode(alu_shifter_opcode),
        .c_select(c_select), .b_select(b_select), .busy(busy), .done(done),
`ifdef UCODE_STEP_LIMIT_EN
        .step_err(err_w),
`endif
        .ucode_we(ucode_we), .ucode_addr(ucode_addr), .ucode_wdata(ucode_wdata)
    );
`ifndef UCODE_STEP_LIMIT_EN
    assign err_w = 1'b0;
`endif

    // Expected output vector: {ready, busy, done, alu, c_select, b_select, step_err}
    localparam logic [24:0] IDL = {3'b100, 22'b0};
    localparam logic [24:0] DN  = {3'b101, 22'b0};
    function automatic logic [31:0] mk(input logic [7:0] a, input logic [8:0] c, input logic [3:0] b,
                                       input logic [2:0] cd, input logic [7:0] nx);
        mk = {a, c, b, cd, nx};
    endfunction
    function automatic logic [24:0] run(input logic [31:0] w);
        run = {3'b010, w[31:11], 1'b0};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask
    task automatic chk(input string nm, input logic [24:0] exp);
        logic [24:0] act;
        act = {instr_ready, busy, done, alu_shifter_opcode, c_select, b_select, err_w};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    task automatic load(input logic [7:0] a, input logic [31:0] w);
        ucode_we = 1'b1;
        ucode_addr = a;
        ucode_wdata = w;
        tick();
        ucode_we = 1'b0;
    endtask
    task automatic disp(input logic [7:0] op);
        instr_valid = 1'b1;
        instr_opcode = op;
        chk("dispatch_idle", IDL);
        tick();
        instr_valid = 1'b0;
    endtask

    typedef struct {
        logic v;
        logic [7:0] op;
        logic we;
        logic [31:0] d;
        logic [24:0] exp;
    } vec_t;
    vec_t vt[12];

    // Reference model: run flag, program counter and flags derived from the cond table.
    logic [31:0] mm [256];
    bit m_run, m_done, m_n, m_z, m_err;
    int m_pc, m_steps;
    task automatic model_step();
        logic [31:0] w;
        int c;
        bit tk, nd;
        nd = 0;
        if (!m_run) begin
            if (ucode_we) mm[ucode_addr] = ucode_wdata;
            if (instr_valid) begin
                m_run = 1; m_pc = instr_opcode; m_n = 0; m_z = 0; m_steps = 0;
            end
        end else begin
            w = mm[m_pc];
            c = int'(w[10:8]);
            tk = (c == 1) || (c == 2 && m_n) || (c == 3 && m_z) || (c == 4 && !m_n) || (c == 5 && !m_z);
            if (c >= 6) begin
                m_run = 0; nd = 1;
            end else if (LIMIT && m_steps == MS - 1) begin
                m_run = 0; m_err = 1;
            end else begin
                m_pc = tk ? int'(w[7:0]) : (m_pc + 1) % 256;
            end
            m_steps++;
            m_n = n;
            m_z = z;
        end
        m_done = nd;
    endtask
    function automatic logic [24:0] model_exp();
        logic [31:0] w;
        w = m_run ? mm[m_pc] : 32'h0;
        model_exp = {!m_run, m_run, m_done, w[31:11], m_err};
    endfunction
    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        int r;
        w = $urandom;
        r = $urandom_range(0, 9);
        w[10:8] = r < 2 ? 3'd6 : r == 2 ? 3'd7 : 3'($urandom_range(0, 5));
        rand_word = w;
    endfunction

    initial begin
        logic [31:0] w10, w11, w30, wbad, wnew, w20, w21, wff, w00, w;
        w10  = mk(8'h05, 9'h004, 4'd3, 3'd0, 8'h00);
        w11  = mk(8'hA1, 9'h1FF, 4'd7, 3'd6, 8'h00);
        w30  = mk(8'h33, 9'h030, 4'd3, 3'd6, 8'h00);
        wbad = mk(8'hEE, 9'h0EE, 4'hE, 3'd6, 8'h00);
        wnew = mk(8'h77, 9'h077, 4'd7, 3'd7, 8'h00);
        vt[0]  = '{1'b1, 8'h10, 1'b0, 32'h0, IDL};
        vt[1]  = '{1'b0, 8'h00, 1'b0, 32'h0, run(w10)};
        vt[2]  = '{1'b0, 8'h00, 1'b0, 32'h0, run(w11)};
        vt[3]  = '{1'b1, 8'h11, 1'b0, 32'h0, DN};
        vt[4]  = '{1'b0, 8'h00, 1'b1, wbad,  run(w11)};
        vt[5]  = '{1'b0, 8'h00, 1'b0, 32'h0, DN};
        vt[6]  = '{1'b1, 8'h30, 1'b0, 32'h0, IDL};
        vt[7]  = '{1'b0, 8'h00, 1'b0, 32'h0, run(w30)};
        vt[8]  = '{1'b1, 8'h30, 1'b1, wnew,  DN};
        vt[9]  = '{1'b0, 8'h00, 1'b0, 32'h0, run(wnew)};
        vt[10] = '{1'b0, 8'h00, 1'b0, 32'h0, DN};
        vt[11] = '{1'b0, 8'h00, 1'b0, 32'h0, IDL};

        tick();
        tick();
        reset = 1'b0;
        chk("reset_state", IDL);

        load(8'h10, w10);
        load(8'h11, w11);
        load(8'h30, w30);
        for (int i = 0; i < 12; i++) begin
            instr_valid = vt[i].v;
            instr_opcode = vt[i].op;
            ucode_we = vt[i].we;
            ucode_addr = 8'h30;
            ucode_wdata = vt[i].d;
            chk($sformatf("vec%0d", i), vt[i].exp);
            tick();
        end
        instr_valid = 1'b0;
        ucode_we = 1'b0;

        // JNZ loop: branch sees the previous word's z, so z=0 then z=1 gives three passes.
        w20 = mk(8'h20, 9'h020, 4'd2, 3'd5, 8'h20);
        w21 = mk(8'h21, 9'h021, 4'd1, 3'd6, 8'h00);
        load(8'h20, w20);
        load(8'h21, w21);
        disp(8'h20);
        z = 1'b0; chk("loop_pass1", run(w20)); tick();
        z = 1'b1; chk("loop_pass2", run(w20)); tick();
        z = 1'b0; chk("loop_pass3", run(w20)); tick();
        chk("loop_fallthrough", run(w21)); tick();
        chk("loop_done", DN); tick();

        wff = mk(8'hFF, 9'h100, 4'd9, 3'd0, 8'h00);
        w00 = mk(8'h01, 9'h001, 4'd1, 3'd6, 8'h00);
        load(8'hFF, wff);
        load(8'h00, w00);
        disp(8'hFF);
        chk("wrap_ff", run(wff)); tick();
        chk("wrap_00", run(w00)); tick();
        chk("wrap_done", DN); tick();

        for (int i = 0; i < 5; i++) load(8'(8'h40 + i), mk(8'(8'h40 + i), 9'(i + 1), 4'(i), i == 4 ? 3'd6 : 3'd0, 8'h00));
        disp(8'h40);
        chk("mid_w0", run(mk(8'h40, 9'd1, 4'd0, 3'd0, 8'h00))); tick();
        chk("mid_w1", run(mk(8'h41, 9'd2, 4'd1, 3'd0, 8'h00)));
        reset = 1'b1; tick(); reset = 1'b0;
        chk("mid_reset", IDL);
        disp(8'h40);
        chk("redisp_w0", run(mk(8'h40, 9'd1, 4'd0, 3'd0, 8'h00))); tick();
        chk("redisp_w1", run(mk(8'h41, 9'd2, 4'd1, 3'd0, 8'h00)));
        reset = 1'b1; tick(); reset = 1'b0;

`ifdef UCODE_STEP_LIMIT_EN
        w = mk(8'h55, 9'h055, 4'd5, 3'd1, 8'h50);
        load(8'h50, w);
        disp(8'h50);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("limit_run%0d", i), run(w));
            tick();
        end
        chk("limit_abort", {3'b100, 21'b0, 1'b1}); tick();
        chk("limit_sticky", {3'b100, 21'b0, 1'b1});
        reset = 1'b1; tick(); reset = 1'b0;
`endif

        for (int a = 0; a < 256; a++) begin
            w = rand_word();
            mm[a] = w;
            load(8'(a), w);
        end
        m_run = 0; m_done = 0; m_n = 0; m_z = 0; m_err = 0; m_pc = 0; m_steps = 0;
        for (int c = 0; c < 3000; c++) begin
            instr_valid = ($urandom_range(0, 2) == 0);
            instr_opcode = 8'($urandom);
            n = 1'($urandom);
            z = 1'($urandom);
            ucode_we = ($urandom_range(0, 3) == 0);
            ucode_addr = 8'($urandom);
            ucode_wdata = rand_word();
            chk($sformatf("random_c%0d", c), model_exp());
            model_step();
            tick();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
